// File: rtl/i2c_slave_if.sv
// i2c_slave_if: pad-side I2C lines plus the parallel byte interface of the I2C target
interface i2c_slave_if;
    logic       i_scl;
    logic       i_sda;
    logic       o_sda_oe;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_tx_req;
    logic [7:0] i_tx_data;
    logic       o_busy;
    logic [3:0] o_status;

    modport slave (
        input  i_scl, i_sda, i_tx_data,
        output o_sda_oe, o_rx_data, o_rx_valid, o_tx_req, o_busy, o_status
    );

    modport master (
        output i_scl, i_sda, i_tx_data,
        input  o_sda_oe, o_rx_data, o_rx_valid, o_tx_req, o_busy, o_status
    );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled 7-bit-address I2C target; optional majority glitch filter via I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input logic        clk0,
    input logic        reset_n,
    i2c_slave_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_f, sda_f, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]             cnt, cnt_n;
    logic [6:0]             shift, shift_n;
    logic [7:0]             rx_data, rx_data_n;
    logic                   oe, oe_n, busy, busy_n, rw, rw_n, addr_match, addr_match_n, nack, nack_n;
    logic                   rx_valid, rx_valid_n, tx_req, tx_req_n, stop_pls, stop_pls_n;

    // bring the asynchronous pad lines into clk0; idle bus level is high
    always_ff @(posedge clk0 or negedge reset_n)
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.i_sda};
        end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;

    // three-sample history; a value must persist two samples to win the vote
    always_ff @(posedge clk0 or negedge reset_n)
        if (!reset_n) begin
            scl_h <= '1;
            sda_h <= '1;
        end else begin
            scl_h <= {scl_h[1:0], scl_sync[SYNC_STAGES-1]};
            sda_h <= {sda_h[1:0], sda_sync[SYNC_STAGES-1]};
        end

    assign scl_f = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda_f = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl_f = scl_sync[SYNC_STAGES-1];
    assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

    // one-cycle delayed copies for edge and START/STOP detection
    always_ff @(posedge clk0 or negedge reset_n)
        if (!reset_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    // state and datapath registers
    always_ff @(posedge clk0 or negedge reset_n)
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            shift      <= '0;
            rx_data    <= '0;
            oe         <= 1'b0;
            busy       <= 1'b0;
            rw         <= 1'b0;
            addr_match <= 1'b0;
            nack       <= 1'b0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            stop_pls   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            rx_data    <= rx_data_n;
            oe         <= oe_n;
            busy       <= busy_n;
            rw         <= rw_n;
            addr_match <= addr_match_n;
            nack       <= nack_n;
            rx_valid   <= rx_valid_n;
            tx_req     <= tx_req_n;
            stop_pls   <= stop_pls_n;
        end

    // next-state logic; START/STOP override bit handling, ACK slots use oe as the first/second-fall marker
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shift_n      = shift;
        rx_data_n    = rx_data;
        oe_n         = oe;
        busy_n       = busy;
        rw_n         = rw;
        addr_match_n = addr_match;
        nack_n       = nack;
        rx_valid_n   = 1'b0;
        tx_req_n     = 1'b0;
        stop_pls_n   = 1'b0;
        if (start_det) begin
            state_n      = S_ADDR;
            cnt_n        = '0;
            oe_n         = 1'b0;
            rw_n         = 1'b0;
            addr_match_n = 1'b0;
            nack_n       = 1'b0;
        end else if (stop_det) begin
            state_n    = S_IDLE;
            oe_n       = 1'b0;
            busy_n     = 1'b0;
            stop_pls_n = 1'b1;
        end else begin
            case (state)
                S_ADDR:
                    if (scl_rise) begin
                        shift_n = {shift[5:0], sda_f};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (shift == SLAVE_ADDR) begin
                                rw_n         = sda_f;
                                addr_match_n = 1'b1;
                                busy_n       = 1'b1;
                                state_n      = S_ADDR_ACK;
                            end else begin
                                busy_n  = 1'b0;
                                state_n = S_IGNORE;
                            end
                        end
                    end
                S_ADDR_ACK: begin
                    tx_req_n = scl_rise & rw;
                    if (scl_fall) begin
                        cnt_n = '0;
                        if (!oe) begin
                            oe_n = 1'b1;
                        end else if (rw) begin
                            shift_n = bus.i_tx_data[6:0];
                            oe_n    = ~bus.i_tx_data[7];
                            state_n = S_TX;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = S_RX;
                        end
                    end
                end
                S_RX:
                    if (scl_rise) begin
                        shift_n = {shift[5:0], sda_f};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            rx_data_n  = {shift, sda_f};
                            rx_valid_n = 1'b1;
                            state_n    = S_RX_ACK;
                        end
                    end
                S_RX_ACK:
                    if (scl_fall) begin
                        oe_n    = ~oe;
                        state_n = oe ? S_RX : S_RX_ACK;
                    end
                S_TX:
                    if (scl_fall) begin
                        cnt_n   = cnt + 3'd1;
                        shift_n = {shift[5:0], 1'b0};
                        oe_n    = (cnt == 3'd7) ? 1'b0 : ~shift[6];
                        state_n = (cnt == 3'd7) ? S_TX_ACK : S_TX;
                    end
                S_TX_ACK: begin
                    if (scl_rise && sda_f) begin
                        nack_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IGNORE;
                    end else begin
                        tx_req_n = scl_rise;
                    end
                    if (scl_fall) begin
                        cnt_n   = '0;
                        shift_n = bus.i_tx_data[6:0];
                        oe_n    = ~bus.i_tx_data[7];
                        state_n = S_TX;
                    end
                end
                S_IGNORE: oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.o_sda_oe   = oe;
    assign bus.o_rx_data  = rx_data;
    assign bus.o_rx_valid = rx_valid;
    assign bus.o_tx_req   = tx_req;
    assign bus.o_busy     = busy;
    assign bus.o_status   = {nack, addr_match, rw, stop_pls};
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with a byte-level reference model for the i2c_slave target
module tb_i2c_slave;
    localparam int Q = 6;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int GLITCH_STOPS = 0;
`else
    localparam int GLITCH_STOPS = 1;
`endif

    logic       clk0 = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, oe_cnt = 0, both_cnt = 0;
    logic [7:0] rx_log [$];
    logic [7:0] exp_rx [$];

    i2c_slave_if bus();

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk0    (clk0),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk0 = ~clk0;

    // open-drain wired-AND of master and target
    assign bus.i_scl = m_scl;
    assign bus.i_sda = m_sda & ~bus.o_sda_oe;

    // pulse and drive-activity monitor
    always @(negedge clk0) begin
        if (bus.o_rx_valid) begin
            rx_cnt++;
            rx_log.push_back(bus.o_rx_data);
        end
        if (bus.o_tx_req) tx_cnt++;
        if (bus.o_status[0]) stop_cnt++;
        if (bus.o_sda_oe) oe_cnt++;
        if (bus.o_rx_valid && bus.o_tx_req) both_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic send_bit(input logic b, output logic line);
        m_sda = b;
        wclk(Q);
        m_scl = 1'b1;
        wclk(Q);
        line = bus.i_sda;
        wclk(Q);
        m_scl = 1'b0;
        wclk(Q);
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        wclk(Q);
        m_scl = 1'b1;
        wclk(Q);
        m_sda = 1'b0;
        wclk(Q);
        m_scl = 1'b0;
        wclk(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        wclk(Q);
        m_scl = 1'b1;
        wclk(Q);
        m_sda = 1'b1;
        wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic l;
        for (int i = 7; i >= 0; i--) send_bit(d[i], l);
        send_bit(1'b1, l);
        ack = ~l;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
        logic l;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, l);
            d[i] = l;
        end
        bus.i_tx_data = next_tx;
        send_bit(~mack, l);
    endtask

    initial begin
        logic       ack, l, exp_ack, rw;
        logic [7:0] d, t;
        logic [6:0] addr;
        logic [7:0] tq [4];
        int         s_rx, s_tx, s_stop, s_oe, n;

        bus.i_tx_data = 8'h00;
        wclk(3);
        check("rst_oe", 32'(bus.o_sda_oe), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_status", 32'(bus.o_status), 32'h0);
        check("rst_rx_data", 32'(bus.o_rx_data), 32'h0);
        check("rst_rx_valid", 32'(bus.o_rx_valid), 32'h0);
        check("rst_tx_req", 32'(bus.o_tx_req), 32'h0);
        reset_n = 1'b1;
        wclk(5);

        // write 0xA5 to 0x50
        s_rx = rx_cnt;
        s_stop = stop_cnt;
        start_c();
        write_byte(8'hA0, ack);
        check("t1_addr_ack", 32'(ack), 32'h1);
        check("t1_busy", 32'(bus.o_busy), 32'h1);
        write_byte(8'hA5, ack);
        exp_rx.push_back(8'hA5);
        check("t1_data_ack", 32'(ack), 32'h1);
        check("t1_rx_data", 32'(bus.o_rx_data), 32'hA5);
        check("t1_rx_pulses", 32'(rx_cnt - s_rx), 32'h1);
        stop_c();
        wclk(2);
        check("t1_busy_after_stop", 32'(bus.o_busy), 32'h0);
        check("t1_stop_pulses", 32'(stop_cnt - s_stop), 32'h1);
        check("t1_status", 32'(bus.o_status), 32'h4);

        // wrong address is ignored
        s_rx = rx_cnt;
        s_oe = oe_cnt;
        start_c();
        write_byte(8'hA2, ack);
        check("t2_addr_nack", 32'(ack), 32'h0);
        write_byte(8'($urandom), ack);
        check("t2_data_nack", 32'(ack), 32'h0);
        check("t2_busy", 32'(bus.o_busy), 32'h0);
        stop_c();
        wclk(2);
        check("t2_oe_cycles", 32'(oe_cnt - s_oe), 32'h0);
        check("t2_rx_pulses", 32'(rx_cnt - s_rx), 32'h0);

        // read 0x3C then 0xC3 with ACK then NACK
        s_tx = tx_cnt;
        bus.i_tx_data = 8'h3C;
        start_c();
        write_byte(8'hA1, ack);
        check("t3_addr_ack", 32'(ack), 32'h1);
        read_byte(1'b1, 8'hC3, d);
        check("t3_byte0", 32'(d), 32'h3C);
        read_byte(1'b0, 8'h00, d);
        check("t3_byte1", 32'(d), 32'hC3);
        check("t3_oe_released", 32'(bus.o_sda_oe), 32'h0);
        check("t3_tx_req_pulses", 32'(tx_cnt - s_tx), 32'h2);
        check("t3_status", 32'(bus.o_status), 32'hE);
        check("t3_busy", 32'(bus.o_busy), 32'h0);
        stop_c();

        // write then repeated START into a read
        d = 8'($urandom);
        t = 8'($urandom);
        start_c();
        write_byte(8'hA0, ack);
        check("t4_addr_ack", 32'(ack), 32'h1);
        write_byte(d, ack);
        exp_rx.push_back(d);
        check("t4_rx_data", 32'(bus.o_rx_data), 32'(d));
        bus.i_tx_data = t;
        start_c();
        check("t4_busy_rstart", 32'(bus.o_busy), 32'h1);
        write_byte(8'hA1, ack);
        check("t4_readdr_ack", 32'(ack), 32'h1);
        check("t4_rw", 32'(bus.o_status[1]), 32'h1);
        read_byte(1'b0, 8'h00, d);
        check("t4_read", 32'(d), 32'(t));
        stop_c();

        // reset in the middle of a read of 0x00
        bus.i_tx_data = 8'h00;
        start_c();
        write_byte(8'hA1, ack);
        check("t5_addr_ack", 32'(ack), 32'h1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, l);
        m_sda = 1'b1;
        wclk(Q);
        m_scl = 1'b1;
        wclk(2);
        check("t5_driving", 32'(bus.o_sda_oe), 32'h1);
        reset_n = 1'b0;
        #1;
        check("t5_oe_async", 32'(bus.o_sda_oe), 32'h0);
        check("t5_busy", 32'(bus.o_busy), 32'h0);
        check("t5_status", 32'(bus.o_status), 32'h0);
        check("t5_rx_data", 32'(bus.o_rx_data), 32'h0);
        wclk(4);
        reset_n = 1'b1;
        wclk(10);
        start_c();
        write_byte(8'hA0, ack);
        check("t5_reack", 32'(ack), 32'h1);
        stop_c();
        wclk(4);

        // one-cycle SDA low pulse while SCL high in idle
        s_stop = stop_cnt;
        @(negedge clk0);
        m_sda = 1'b0;
        wclk(1);
        m_sda = 1'b1;
        wclk(12);
        check("t6_busy", 32'(bus.o_busy), 32'h0);
        check("t6_stop_pulses", 32'(stop_cnt - s_stop), 32'(GLITCH_STOPS));

        // randomized transactions against the byte-level model
        for (int k = 0; k < 6; k++) begin
            addr = $urandom_range(0, 1) ? 7'h50 : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            exp_ack = (addr == 7'h50);
            for (int j = 0; j < 4; j++) tq[j] = 8'($urandom);
            s_tx = tx_cnt;
            bus.i_tx_data = tq[0];
            start_c();
            write_byte({addr, rw}, ack);
            check("rnd_addr_ack", 32'(ack), 32'(exp_ack));
            for (int j = 0; j < n; j++) begin
                if (rw) begin
                    read_byte(j < n - 1, tq[j+1], d);
                    check("rnd_read", 32'(d), exp_ack ? 32'(tq[j]) : 32'hFF);
                end else begin
                    write_byte(tq[j], ack);
                    check("rnd_write_ack", 32'(ack), 32'(exp_ack));
                    if (exp_ack) exp_rx.push_back(tq[j]);
                end
            end
            check("rnd_tx_req", 32'(tx_cnt - s_tx), (exp_ack && rw) ? 32'(n) : 32'h0);
            stop_c();
            wclk(4);
        end

        check("rx_log_size", 32'(rx_log.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_log.size(); i++)
            check("rx_log_entry", 32'(rx_log[i]), 32'(exp_rx[i]));
        check("rx_tx_overlap", 32'(both_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address, 8-bit-data I2C target (slave) that answers the team's i2c_master.
- Oversamples SCL/SDA on the system clock clk0 and detects START, repeated START and STOP.
- Matches a fixed address, ACKs, and moves bytes to and from a parallel byte interface with single-cycle strobes.
- Sits behind the pad open-drain logic. The block only ever pulls SDA low and never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target responds to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on i_scl/i_sda; legal range 2..3.

Ports:
- clk0  input  1  system clock; frequency must be ≥10× SCL frequency.
- reset_n  input  1  reset.
- i_scl  input  1  SCL from pad, asynchronous.
- i_sda  input  1  SDA from pad, asynchronous.
- o_sda_oe  output  1  1 = pull SDA low; 0 = release.
- o_rx_data  output  8  last received write byte; holds until the next byte.
- o_rx_valid  output  1  1-cycle pulse, o_rx_data updated.
- o_tx_req  output  1  1-cycle pulse, i_tx_data is sampled at the next SCL fall.
- i_tx_data  input  8  byte to send on a read.
- o_busy  output  1  addressed transaction in progress (START+match until STOP/NACK/mismatch).
- o_status  output  4  {nack_rcvd, addr_match, rw, stop_det}; stop_det is a 1-cycle pulse.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk0.
- Reset clears all state within the same cycle (asynchronous):
  - o_sda_oe=0, o_rx_valid=0, o_tx_req=0, o_busy=0, o_status=0, o_rx_data=8'h00.
  - state=S_IDLE.
  - Asserting reset mid-byte releases SDA immediately.
- Synchronization and edge detection:
  - i_scl/i_sda pass through SYNC_STAGES flops, then one delay flop for edge detect.
  - scl_rise/scl_fall are 1-cycle pulses.
  - START = SDA falls while SCL=1. STOP = SDA rises while SCL=1.
- Bit timing:
  - SDA is sampled on scl_rise.
  - o_sda_oe changes only on the cycle of scl_fall (or on STOP/START/reset).
- START or repeated START in any state: bit counter=0, o_sda_oe=0, state→S_ADDR. Takes priority over data-bit sampling in the same cycle.
- STOP in any state: →S_IDLE, o_sda_oe=0, o_busy=0, stop_det pulse.
- States:
  - S_IDLE: wait for START.
  - S_ADDR: shift 8 bits MSB first.
    - After the 8th scl_rise, compare [7:1] with SLAVE_ADDR.
    - Match: latch rw=[0], set addr_match=1, o_busy=1, →S_ADDR_ACK.
    - Mismatch: →S_IGNORE.
  - S_ADDR_ACK:
    - o_sda_oe=1 from the scl_fall ending bit 8 until the scl_fall ending the ACK bit.
    - If rw=1, pulse o_tx_req on the ACK-bit scl_rise, load the shift register from i_tx_data at the ending scl_fall, and drive bit7. →S_TX.
    - If rw=0 →S_RX.
  - S_RX:
    - 8 bits MSB first; 3-bit counter wraps 7→0.
    - The cycle after the 8th scl_rise: o_rx_data updates and o_rx_valid pulses.
    - →S_RX_ACK; always ACK (oe=1 for the 9th clock), then →S_RX.
  - S_TX:
    - o_sda_oe = ~shift[7] at each scl_fall.
    - After the 8th bit's scl_fall: release SDA, →S_TX_ACK.
  - S_TX_ACK: sample the master's bit on scl_rise.
    - SDA=0 (ACK): pulse o_tx_req and reload at the next scl_fall, →S_TX.
    - SDA=1 (NACK): nack_rcvd=1, →S_IGNORE with SDA released.
  - S_IGNORE: SDA released; wait for START/STOP.
- Status fields:
  - addr_match, rw and nack_rcvd clear on the next START.
  - o_rx_valid and o_tx_req never assert in the same cycle.

Optional Feature:
- Macro I2C_SLAVE_GLITCH_FILTER_EN.
- Defined:
  - After the synchronizer, each line passes a 3-sample majority filter.
  - Adds 2 clk0 cycles of latency to all edge and START/STOP detection.
  - Rejects pulses ≤1 clk0 cycle wide.
- Undefined:
  - Synchronizer only.
  - A 1-cycle SDA glitch while SCL=1 is decoded as START/STOP.

Test Plan:
1. Write to address 0x50 (byte 0xA0), then data 0xA5, then STOP → ACK on both 9th bits; one o_rx_valid pulse with o_rx_data=0xA5; o_busy 1→0 at STOP; stop_det pulses once.
2. Address byte 0xA2 (addr 0x51) → o_sda_oe stays 0 for the whole transfer; o_busy=0; no o_rx_valid.
3. Read 0xA1; i_tx_data=0x3C then 0xC3; master ACK then NACK → SDA carries 0x3C then 0xC3; two o_tx_req pulses; nack_rcvd=1; SDA released after the NACK.
4. Write 0xA0, data 0x12, then repeated START + 0xA1 read → rx 0x12 valid; rw=1 after the re-address; o_busy stays 1 across the repeated START.
5. Assert reset_n low during bit 4 of a read byte 0x00 → o_sda_oe=0 in the same cycle; all outputs at reset values; the next START+0xA0 is ACKed normally.
6. With I2C_SLAVE_GLITCH_FILTER_EN defined, inject a 1-cycle SDA low pulse while SCL=1 in S_IDLE → no START detected; o_busy=0.
